byte_striping_nlane: RTL and testbench
======================================

# byte_striping_nlane

Parametrised successor to the two-lane byte striper: distributes a stream of DATA_W-bit words round-robin across a runtime-selectable number of lanes (up to LANES). Words are staged until a full lane group is assembled, then presented on all active lanes in the same cycle. A flush input emits partial groups. Sits between the link-layer word source and the per-lane encoders/serialisers.

## Interface
- DATA_W, 32, width of one input word and of each lane.
- LANES, 4, maximum lane count; power of two, ≥ 2.
- CNT_W, $clog2(LANES)+1, width of the lane-count field.

- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- valid_in  in  1  data_in carries a word this cycle.
- data_in  in  DATA_W  input word.
- flush  in  1  emit the current partial group.
- active_lanes  in  CNT_W  requested lane count; legal values are 1, 2, 4, … LANES.
- lane_out  out  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- valid_out  out  LANES  per-lane valid; one-cycle pulse per group.
- cfg_err  out  1  one-cycle pulse when an illegal active_lanes value is sampled.

## Operation
- Internal state:
  - stage[LANES] holds DATA_W-bit staging words.
  - ptr (0..LANES-1) is the fill pointer.
  - cur_lanes is the latched lane count.
- FSM with two states, IDLE (ptr==0) and FILL (ptr>0):
  - IDLE → FILL on an accepted word when cur_lanes > 1.
  - FILL → IDLE on group completion or flush.
- Lane-count latching:
  - active_lanes is sampled only in IDLE, every cycle, including a cycle in which a word is accepted to lane 0. The value sampled in that cycle governs the group starting with that word.
  - Changes to active_lanes during FILL are ignored until the next IDLE cycle.
  - An illegal value (0, not a power of two, or > LANES) keeps the previous cur_lanes and pulses cfg_err on the next cycle.
- Accepted word (valid_in=1) is written to stage[ptr], then ptr increments.
- Group completion: an accepted word with ptr == cur_lanes-1.
  - Next cycle: lane_out[i] = stage[i] for i < cur_lanes, with the completing word in slot ptr.
  - valid_out[i]=1 for i < cur_lanes.
  - Inactive lanes drive 0 with valid 0.
  - ptr returns to 0.
  - With cur_lanes==1 every accepted word completes a group.
- Flush:
  - In FILL, or in the same cycle as an accepted word, flush emits stage[0..k-1] next cycle. k is ptr, plus 1 if a word is accepted that cycle.
  - valid_out[i]=1 for i<k; lanes ≥ k drive 0.
  - ptr returns to 0.
  - Flush in IDLE with no accepted word has no effect.
  - Flush coinciding with group completion is identical to a plain completion.
- Between emits:
  - lane_out holds the last emitted value.
  - valid_out = 0.
- No backpressure: one word per cycle is always accepted.
- Reset values:
  - lane_out = 0, valid_out = 0, cfg_err = 0.
  - ptr = 0, stage = 0, cur_lanes = LANES.
- Reset mid-group discards staged words; no emit follows.

## Timing
- Latency is 1 cycle: completing word or flush at cycle t → valid_out at t+1.
- Throughput: back-to-back groups sustainable. A new group may begin in the same cycle the previous group's emit is registered.
- All outputs are registered; no combinational input→output path.
- cfg_err asserts at t+1 for an illegal sample at t.

## Structure
- Shared package byte_striping_pkg holds:
  - the lane-count legality function (power of two and ≤ LANES);
  - the $clog2 helper;
  - the FSM state encoding IDLE/FILL.
- One sub-module, lane_stage_buf, holds the LANES×DATA_W staging registers. It provides the write port (ptr, data, we) and the parallel read/zero-mask for emit.
- The top holds ptr, cur_lanes, the FSM and the output registers.

## Test plan
- Reset, then active_lanes=4, words 0xA0..0xA3 on consecutive cycles → cycle after 0xA3: lanes 0..3 = A0,A1,A2,A3, valid_out=4'b1111. Then valid_out returns to 0000 with lane_out held.
- active_lanes=2, words 0x11,0x22,0x33,0x44 back-to-back → two emits on consecutive-group boundaries: {11,22} with valid 0011, then {33,44} with valid 0011. Lanes 2–3 = 0.
- active_lanes=4, words 0x5,0x6, then flush with valid_in=0 → next cycle lanes {5,6,0,0}, valid 0011, ptr back to 0.
- active_lanes=3 in IDLE → cfg_err pulses 1 cycle, cur_lanes stays at prior value (4). Then active_lanes changed 4→1 mid-group → current group still completes as 4 lanes, following words emit singly on lane 0 with valid 0001.
- Assert reset after 3 of 4 words, then release → no emit, all outputs 0. A fresh 4-word group emits correctly.

Source files
------------

// File: rtl/byte_striping_pkg.sv
// Shared helpers for the N-lane byte striper: FSM encoding, log2 helper
// and the lane-count legality check.
package byte_striping_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Legal lane counts are non-zero powers of two not exceeding max_lanes.
  function automatic logic lanes_legal(input logic [31:0] req, input int unsigned max_lanes);
    return (req != 32'd0) && ((req & (req - 32'd1)) == 32'd0) && (req <= 32'(max_lanes));
  endfunction

endpackage

// File: rtl/byte_striping_nlane_if.sv
// Word-in / lanes-out bundle of the striper.
//   valid_in, data_in, flush, active_lanes : source -> striper
//   lane_out, valid_out, cfg_err           : striper -> lane encoders
interface byte_striping_nlane_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 4
);
  localparam int unsigned CNT_W = byte_striping_pkg::clog2_f(LANES) + 1;

  logic                    valid_in;
  logic [DATA_W-1:0]       data_in;
  logic                    flush;
  logic [CNT_W-1:0]        active_lanes;
  logic [LANES*DATA_W-1:0] lane_out;
  logic [LANES-1:0]        valid_out;
  logic                    cfg_err;

  modport master (
    output valid_in, data_in, flush, active_lanes,
    input  lane_out, valid_out, cfg_err
  );

  modport slave (
    input  valid_in, data_in, flush, active_lanes,
    output lane_out, valid_out, cfg_err
  );
endinterface

// File: rtl/byte_striping_nlane_lane_stage_buf.sv
// Staging registers for one lane group.
//   clk, reset         : clock, synchronous active-high reset
//   we, wr_ptr, wr_data: write port into slot wr_ptr
//   rd_cnt, rd_data    : parallel read of slots < rd_cnt, higher slots zeroed;
//                        a word being written this cycle is forwarded.
module lane_stage_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned PTR_W  = 2,
  parameter int unsigned CNT_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [PTR_W-1:0]        wr_ptr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [CNT_W-1:0]        rd_cnt,
  output logic [LANES*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] stage_q [LANES];
  logic [DATA_W-1:0] stage_d [LANES];

  // Write port.
  always_comb begin
    for (int i = 0; i < LANES; i++) stage_d[i] = stage_q[i];
    if (we) stage_d[wr_ptr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) stage_q[i] <= stage_d[i];
    end
  end

  // Masked read with forwarding so the completing word lands in its slot.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (CNT_W'(i) < rd_cnt) begin
        rd_data[i*DATA_W +: DATA_W] = (we && (PTR_W'(i) == wr_ptr)) ? wr_data : stage_q[i];
      end
    end
  end

endmodule

// File: rtl/byte_striping_nlane.sv
// Round-robin word striper across a runtime-selectable number of lanes.
//   clk, reset : clock, synchronous active-high reset
//   bus        : valid_in/data_in/flush/active_lanes in,
//                lane_out/valid_out/cfg_err out (all registered)
module byte_striping_nlane
  import byte_striping_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  byte_striping_nlane_if.slave  bus
);

  localparam int unsigned PTR_W = clog2_f(LANES);
  localparam int unsigned CNT_W = clog2_f(LANES) + 1;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cur_lanes_q, cur_lanes_d;
  logic [LANES*DATA_W-1:0] lane_out_q, lane_out_d;
  logic [LANES-1:0]        valid_out_q, valid_out_d;
  logic                    cfg_err_q, cfg_err_d;

  logic [CNT_W-1:0]        eff_lanes;
  logic [CNT_W-1:0]        emit_cnt;
  logic                    accept;
  logic                    complete;
  logic                    emit;
  logic [LANES*DATA_W-1:0] emit_data;

  lane_stage_buf #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .PTR_W  (PTR_W),
    .CNT_W  (CNT_W)
  ) u_stage (
    .clk     (clk),
    .reset   (reset),
    .we      (accept),
    .wr_ptr  (ptr_q),
    .wr_data (bus.data_in),
    .rd_cnt  (emit_cnt),
    .rd_data (emit_data)
  );

  // Lane-count sampling, group completion/flush decode and pointer update.
  // In IDLE the freshly sampled count already governs a word accepted to lane 0.
  always_comb begin
    cur_lanes_d = cur_lanes_q;
    cfg_err_d   = 1'b0;
    eff_lanes   = cur_lanes_q;
    accept      = bus.valid_in;
    if (state_q == IDLE) begin
      if (lanes_legal(32'(bus.active_lanes), LANES)) begin
        eff_lanes   = bus.active_lanes;
        cur_lanes_d = bus.active_lanes;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
    complete = accept && (CNT_W'(ptr_q) == (eff_lanes - CNT_W'(1)));
    emit     = complete || (bus.flush && ((state_q == FILL) || accept));
    emit_cnt = complete ? eff_lanes : (CNT_W'(ptr_q) + CNT_W'(accept));
    if (emit)        ptr_d = '0;
    else if (accept) ptr_d = ptr_q + PTR_W'(1);
    else             ptr_d = ptr_q;
    state_d = (ptr_d == '0) ? IDLE : FILL;
  end

  // Output staging: lanes hold between emits, valid is a one-cycle pulse.
  always_comb begin
    lane_out_d  = lane_out_q;
    valid_out_d = '0;
    if (emit) begin
      lane_out_d = emit_data;
      for (int i = 0; i < LANES; i++) valid_out_d[i] = (CNT_W'(i) < emit_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cur_lanes_q <= CNT_W'(LANES);
      lane_out_q  <= '0;
      valid_out_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_lanes_q <= cur_lanes_d;
      lane_out_q  <= lane_out_d;
      valid_out_q <= valid_out_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bus.lane_out  = lane_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_byte_striping_nlane.sv
// Directed bench for byte_striping_nlane (DATA_W=32, LANES=4).
module tb_byte_striping_nlane;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  byte_striping_nlane_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

  byte_striping_nlane #(.DATA_W(DATA_W), .LANES(LANES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [127:0] lanes(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic word(input logic [31:0] d);
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    tick();
  endtask

  task automatic idle();
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    tick();
  endtask

  initial begin
    reset            = 1'b1;
    bus.valid_in     = 1'b0;
    bus.data_in      = '0;
    bus.flush        = 1'b0;
    bus.active_lanes = 3'd4;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_lane", bus.lane_out, '0);
    chk("rst_valid", 128'(bus.valid_out), 128'h0);
    chk("rst_cfg", 128'(bus.cfg_err), 128'h0);

    // Four-lane group
    word(32'hA0);
    word(32'hA1);
    word(32'hA2);
    chk("g4_partial_valid", 128'(bus.valid_out), 128'h0);
    word(32'hA3);
    chk("g4_lane", bus.lane_out, lanes(32'hA0, 32'hA1, 32'hA2, 32'hA3));
    chk("g4_valid", 128'(bus.valid_out), 128'hF);
    idle();
    chk("g4_after_valid", 128'(bus.valid_out), 128'h0);
    chk("g4_after_hold", bus.lane_out, lanes(32'hA0, 32'hA1, 32'hA2, 32'hA3));

    // Two-lane groups back to back
    bus.active_lanes = 3'd2;
    word(32'h11);
    word(32'h22);
    chk("g2a_lane", bus.lane_out, lanes(32'h11, 32'h22, 0, 0));
    chk("g2a_valid", 128'(bus.valid_out), 128'h3);
    word(32'h33);
    chk("g2_gap_valid", 128'(bus.valid_out), 128'h0);
    word(32'h44);
    chk("g2b_lane", bus.lane_out, lanes(32'h33, 32'h44, 0, 0));
    chk("g2b_valid", 128'(bus.valid_out), 128'h3);
    idle();
    chk("g2_after_valid", 128'(bus.valid_out), 128'h0);

    // Flush of a partial group with no word
    bus.active_lanes = 3'd4;
    word(32'h5);
    word(32'h6);
    chk("fl_pre_valid", 128'(bus.valid_out), 128'h0);
    bus.valid_in = 1'b0;
    bus.flush    = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fl_lane", bus.lane_out, lanes(32'h5, 32'h6, 0, 0));
    chk("fl_valid", 128'(bus.valid_out), 128'h3);
    idle();
    chk("fl_after_valid", 128'(bus.valid_out), 128'h0);

    // Illegal lane count, then a mid-group change that must be ignored
    bus.active_lanes = 3'd3;
    idle();
    chk("cfg_err_pulse", 128'(bus.cfg_err), 128'h1);
    word(32'hB0);
    chk("cfg_err_word", 128'(bus.cfg_err), 128'h1);
    chk("cfg_keep4_valid", 128'(bus.valid_out), 128'h0);
    bus.active_lanes = 3'd1;
    word(32'hB1);
    chk("cfg_err_fill", 128'(bus.cfg_err), 128'h0);
    chk("midchg_valid", 128'(bus.valid_out), 128'h0);
    word(32'hB2);
    word(32'hB3);
    chk("midchg_lane", bus.lane_out, lanes(32'hB0, 32'hB1, 32'hB2, 32'hB3));
    chk("midchg_valid4", 128'(bus.valid_out), 128'hF);
    word(32'hC0);
    chk("one_a_lane", bus.lane_out, lanes(32'hC0, 0, 0, 0));
    chk("one_a_valid", 128'(bus.valid_out), 128'h1);
    word(32'hC1);
    chk("one_b_lane", bus.lane_out, lanes(32'hC1, 0, 0, 0));
    chk("one_b_valid", 128'(bus.valid_out), 128'h1);
    idle();
    chk("one_after_valid", 128'(bus.valid_out), 128'h0);

    // Flush in IDLE with no word does nothing
    bus.flush = 1'b1;
    idle();
    bus.flush = 1'b0;
    chk("idle_flush_valid", 128'(bus.valid_out), 128'h0);
    chk("idle_flush_hold", bus.lane_out, lanes(32'hC1, 0, 0, 0));

    // Flush together with an accepted word
    bus.active_lanes = 3'd4;
    word(32'hD0);
    bus.flush = 1'b1;
    word(32'hD1);
    bus.flush = 1'b0;
    chk("flw_lane", bus.lane_out, lanes(32'hD0, 32'hD1, 0, 0));
    chk("flw_valid", 128'(bus.valid_out), 128'h3);

    // Reset mid-group discards staged words
    word(32'hE0);
    word(32'hE1);
    word(32'hE2);
    bus.valid_in = 1'b0;
    reset        = 1'b1;
    tick();
    chk("midrst_lane", bus.lane_out, '0);
    chk("midrst_valid", 128'(bus.valid_out), 128'h0);
    reset = 1'b0;
    tick();
    chk("postrst_lane", bus.lane_out, '0);
    chk("postrst_valid", 128'(bus.valid_out), 128'h0);
    word(32'hF0);
    word(32'hF1);
    word(32'hF2);
    chk("postrst_partial", 128'(bus.valid_out), 128'h0);
    word(32'hF3);
    chk("fresh_lane", bus.lane_out, lanes(32'hF0, 32'hF1, 32'hF2, 32'hF3));
    chk("fresh_valid", 128'(bus.valid_out), 128'hF);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
